// File: rtl/pc_next_unit.sv
// Program-counter unit: owns the PC register and picks the next PC from PC+INC or an external target.
// While PC_WE is low, a redirect is parked in a buffer and applied on release; misaligned targets are rejected.
module pc_next_unit #(
  parameter int               XLEN       = 32,
  parameter int               NUM_SRC    = 6,
  parameter logic [XLEN-1:0]  RESET_VEC  = '0,
  parameter int               INC        = 4,
  parameter int               ALIGN_BITS = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       PC_WE,
  input  logic [$clog2(NUM_SRC)-1:0] SEL,
  input  logic [NUM_SRC*XLEN-1:0]    SRC,
  output logic [XLEN-1:0]            PC,
  output logic [XLEN-1:0]            PC_PLUS,
  output logic                       PEND,
  output logic                       MISALIGN
);

  localparam int SEL_W = $clog2(NUM_SRC);

  typedef enum logic {RUN, HOLD} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pb_q, pb_d;
  logic              mis_q, mis_d;

  logic [XLEN-1:0]   src_arr [NUM_SRC];
  logic [SEL_W-1:0]  eff_sel;
  logic              redirect;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   rel_tgt;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
    assign src_arr[k] = SRC[k*XLEN +: XLEN];
  end

  assign PC_PLUS = pc_q + XLEN'(INC);

  // Out-of-range selects fall back to sequential fetch.
  assign eff_sel  = (int'(SEL) >= NUM_SRC) ? '0 : SEL;
  assign redirect = (eff_sel != '0);
  assign target   = redirect ? src_arr[eff_sel] : PC_PLUS;
  // On release from HOLD, a fresh redirect overrides the buffered one.
  assign rel_tgt  = redirect ? target : pb_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pb_d    = pb_q;
    mis_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (PC_WE) begin
          if (redirect && (target[ALIGN_BITS-1:0] != '0)) mis_d = 1'b1;
          else                                           pc_d  = target;
        end else if (redirect) begin
          pb_d    = target;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!PC_WE) begin
          if (redirect) pb_d = target;
        end else begin
          if (rel_tgt[ALIGN_BITS-1:0] != '0) mis_d = 1'b1;
          else                               pc_d  = rel_tgt;
          pb_d    = '0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      pc_q    <= RESET_VEC;
      pb_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pb_q    <= pb_d;
      mis_q   <= mis_d;
    end
  end

  assign PC       = pc_q;
  assign PEND     = (state_q == HOLD);
  assign MISALIGN = mis_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: each step queues the expected PC/PEND/MISALIGN,
// the observed values are queued after the edge, and each test task compares them.
module tb_pc_next_unit;

  localparam int XLEN    = 32;
  localparam int NUM_SRC = 6;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pend;
    logic            mis;
  } obs_t;

  logic                    CLK;
  logic                    RST;
  logic                    PC_WE;
  logic [2:0]              SEL;
  logic [NUM_SRC*XLEN-1:0] SRC;
  logic [XLEN-1:0]         PC;
  logic [XLEN-1:0]         PC_PLUS;
  logic                    PEND;
  logic                    MISALIGN;

  logic [XLEN-1:0] src_arr [NUM_SRC];
  obs_t            exp_q[$];
  obs_t            obs_q[$];
  int              n_chk  = 0;
  int              n_fail = 0;

  pc_next_unit #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .RESET_VEC(32'h0), .INC(4), .ALIGN_BITS(2)) dut (
    .CLK(CLK), .RST(RST), .PC_WE(PC_WE), .SEL(SEL), .SRC(SRC),
    .PC(PC), .PC_PLUS(PC_PLUS), .PEND(PEND), .MISALIGN(MISALIGN)
  );

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign SRC[k*XLEN +: XLEN] = src_arr[k];
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Drive one cycle, queue its expectation, then record what the DUT shows after the edge.
  task automatic drv(input logic rst, input logic we, input int sel, input logic [XLEN-1:0] val,
                     input logic [XLEN-1:0] epc, input logic epd, input logic em);
    obs_t e, o;
    RST   = rst;
    PC_WE = we;
    SEL   = 3'(sel);
    if (sel >= 1 && sel < NUM_SRC) src_arr[sel] = val;
    e.pc = epc; e.pend = epd; e.mis = em;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    o.pc = PC; o.pend = PEND; o.mis = MISALIGN;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    obs_t e, o;
    int   i = 0;
    drv(1, 0, 0, 0, 32'h0, 0, 0);
    drv(0, 1, 0, 0, 32'h4, 0, 0);
    drv(0, 1, 0, 0, 32'h8, 0, 0);
    drv(0, 1, 0, 0, 32'hC, 0, 0);
    n_chk++;
    if (PC_PLUS !== 32'h10) begin
      n_fail++;
      $display("FAIL reset_pc_plus: got %h want %h", PC_PLUS, 32'h10);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got pc=%h pend=%b mis=%b want pc=%h pend=%b mis=%b",
                 i, o.pc, o.pend, o.mis, e.pc, e.pend, e.mis);
      end
      i++;
    end
  endtask

  task automatic test_redirect();
    obs_t e, o;
    int   i = 0;
    drv(0, 1, 1, 32'h100,  32'h100,  0, 0);
    drv(0, 1, 3, 32'h2000, 32'h2000, 0, 0);
    drv(0, 1, 0, 0,        32'h2004, 0, 0);
    drv(0, 1, 5, 32'h3000, 32'h3000, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL redirect[%0d]: got pc=%h pend=%b mis=%b want pc=%h pend=%b mis=%b",
                 i, o.pc, o.pend, o.mis, e.pc, e.pend, e.mis);
      end
      i++;
    end
  endtask

  task automatic test_stall_redirect();
    obs_t e, o;
    int   i = 0;
    drv(0, 1, 1, 32'h40,  32'h40,  0, 0);
    drv(0, 0, 1, 32'h800, 32'h40,  1, 0);
    drv(0, 0, 0, 0,       32'h40,  1, 0);
    drv(0, 0, 0, 0,       32'h40,  1, 0);
    drv(0, 1, 0, 0,       32'h800, 0, 0);
    drv(0, 1, 0, 0,       32'h804, 0, 0);
    drv(0, 0, 0, 0,       32'h804, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL stall[%0d]: got pc=%h pend=%b mis=%b want pc=%h pend=%b mis=%b",
                 i, o.pc, o.pend, o.mis, e.pc, e.pend, e.mis);
      end
      i++;
    end
  endtask

  task automatic test_latest_wins();
    obs_t e, o;
    int   i = 0;
    drv(0, 0, 1, 32'h800, 32'h804, 1, 0);
    drv(0, 0, 2, 32'h900, 32'h804, 1, 0);
    drv(0, 1, 0, 0,       32'h900, 0, 0);
    drv(0, 0, 1, 32'h800, 32'h900, 1, 0);
    drv(0, 1, 4, 32'hA00, 32'hA00, 0, 0);
    // A buffered misaligned target is only rejected when released.
    drv(0, 0, 2, 32'hB01, 32'hA00, 1, 0);
    drv(0, 1, 0, 0,       32'hA00, 0, 1);
    drv(0, 1, 0, 0,       32'hA04, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL latest[%0d]: got pc=%h pend=%b mis=%b want pc=%h pend=%b mis=%b",
                 i, o.pc, o.pend, o.mis, e.pc, e.pend, e.mis);
      end
      i++;
    end
  endtask

  task automatic test_misalign();
    obs_t e, o;
    int   i = 0;
    drv(0, 1, 1, 32'h10,   32'h10, 0, 0);
    drv(0, 1, 1, 32'h1002, 32'h10, 0, 1);
    drv(0, 1, 7, 0,        32'h14, 0, 0);
    drv(0, 1, 6, 0,        32'h18, 0, 0);
    drv(0, 1, 3, 32'h2001, 32'h18, 0, 1);
    drv(0, 0, 0, 0,        32'h18, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL misalign[%0d]: got pc=%h pend=%b mis=%b want pc=%h pend=%b mis=%b",
                 i, o.pc, o.pend, o.mis, e.pc, e.pend, e.mis);
      end
      i++;
    end
  endtask

  task automatic test_wrap_reset();
    obs_t e, o;
    int   i = 0;
    drv(0, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0);
    n_chk++;
    if (PC_PLUS !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_pc_plus: got %h want %h", PC_PLUS, 32'h0);
    end
    drv(0, 1, 0, 0,       32'h0, 0, 0);
    drv(0, 1, 0, 0,       32'h4, 0, 0);
    drv(0, 0, 2, 32'h700, 32'h4, 1, 0);
    drv(1, 1, 2, 32'h700, 32'h0, 0, 0);
    drv(0, 1, 0, 0,       32'h4, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap_reset[%0d]: got pc=%h pend=%b mis=%b want pc=%h pend=%b mis=%b",
                 i, o.pc, o.pend, o.mis, e.pc, e.pend, e.mis);
      end
      i++;
    end
  endtask

  initial begin
    RST   = 1'b1;
    PC_WE = 1'b0;
    SEL   = '0;
    for (int k = 0; k < NUM_SRC; k++) src_arr[k] = '0;
    test_reset();
    test_redirect();
    test_stall_redirect();
    test_latest_wins();
    test_misalign();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
